// File: rtl/mem_rd_arbiter.sv
// ---------------------------------------------------------------------------
// mem_rd_arbiter
//
// Shares the single host-memory read channel among four loaders:
//   idx 0 = CPU instruction fetch (INSTR)
//   idx 1 = RNN weight loader     (RNN_W)
//   idx 2 = DNN weight loader     (DNN_W)
//   idx 3 = image loader          (IMAGE)
// Requests are granted round-robin. One read is issued on mem_tx, and the
// arbiter then waits for the matching status on mem_rx_status. It reports
// done, or err on timeout, back to the owner. Only one read is outstanding
// at any time.
//
// Encodings (mem_tx.req_type and mem_rx_status share the numbering):
//   0 = NONE / NONE_VALID, 1 = INSTR, 2 = RNN_W, 3 = DNN_W, 4 = IMAGE
//
// Parameters
//   TIMEOUT_CYCLES  maximum WAIT cycles before the request is abandoned (>=2)
//
// Ports
//   clk            in   1    single clock, rising edge
//   rst            in   1    asynchronous, active-high reset
//   req_valid      in   4    per-requester read request
//   req_addr       in   256  four 64-bit addresses, requester i at [i*64 +: 64]
//   req_ack        out  4    1-cycle pulse: request accepted and issued
//   rsp_done       out  4    1-cycle pulse: matching status received
//   rsp_err        out  4    1-cycle pulse: request timed out
//   mem_tx         out  67   {req_type[2:0], addr[63:0]} to the memory interface
//   mem_rx_status  in   3    response status from the memory interface
//   busy           out  1    high while a request is in ISSUE or WAIT
//   grant_id       out  2    index of the current owner; valid while busy
// ---------------------------------------------------------------------------
module mem_rd_arbiter #(
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [3:0]   req_valid,
    input  logic [255:0] req_addr,
    output logic [3:0]   req_ack,
    output logic [3:0]   rsp_done,
    output logic [3:0]   rsp_err,
    output logic [66:0]  mem_tx,
    input  logic [2:0]   mem_rx_status,
    output logic         busy,
    output logic [1:0]   grant_id
);

    localparam int              TIMER_W    = $clog2(TIMEOUT_CYCLES);
    localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(TIMEOUT_CYCLES - 1);
    localparam logic [2:0]      REQ_NONE   = 3'd0;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT
    } state_t;

    state_t               state;
    state_t               state_d;

    logic [1:0]           rr_ptr;
    logic [1:0]           rr_ptr_d;
    logic [1:0]           grant_q;
    logic [1:0]           grant_d;
    logic [63:0]          addr_q;
    logic [63:0]          addr_d;
    logic [TIMER_W-1:0]   timer_q;
    logic [TIMER_W-1:0]   timer_d;
    logic [2:0]           tx_type_q;
    logic [2:0]           tx_type_d;
    logic [3:0]           ack_d;
    logic [3:0]           done_d;
    logic [3:0]           err_d;

    logic                 pick_valid;
    logic [1:0]           pick_idx;
    logic [1:0]           cand;
    logic                 status_match;

    // The request type and the address are both held in registers, so
    // mem_tx is a registered output. The address is kept after the issue
    // cycle because the memory side may still look at it during WAIT.
    assign mem_tx   = {tx_type_q, addr_q};
    assign busy     = (state != ST_IDLE);
    assign grant_id = grant_q;

    // Round-robin pick. The search starts at rr_ptr and wraps modulo 4.
    // The 2-bit addition wraps naturally. The first requester found wins,
    // and later candidates cannot override it.
    always_comb begin
        pick_valid = 1'b0;
        pick_idx   = rr_ptr;
        cand       = rr_ptr;
        for (int i = 0; i < 4; i++) begin
            cand = rr_ptr + 2'(i);
            if (!pick_valid && req_valid[cand]) begin
                pick_valid = 1'b1;
                pick_idx   = cand;
            end
        end
    end

    // A response belongs to the current owner only when its status code
    // equals the owner's request type (grant index + 1). Any other code,
    // including NONE_VALID, is treated as noise.
    always_comb begin
        status_match = (mem_rx_status == ({1'b0, grant_q} + 3'd1));
    end

    // Next-state and next-output logic. Every output pulse is computed one
    // cycle ahead and registered, so req_ack/mem_tx appear in the ISSUE
    // cycle, and rsp_done/rsp_err appear in the IDLE cycle that follows the
    // deciding WAIT cycle. The match test comes before the timeout test, so
    // a match on the last allowed WAIT cycle still counts as done.
    always_comb begin
        state_d   = state;
        rr_ptr_d  = rr_ptr;
        grant_d   = grant_q;
        addr_d    = addr_q;
        timer_d   = timer_q;
        tx_type_d = REQ_NONE;
        ack_d     = 4'b0000;
        done_d    = 4'b0000;
        err_d     = 4'b0000;

        case (state)
            ST_IDLE: begin
                if (pick_valid) begin
                    state_d         = ST_ISSUE;
                    grant_d         = pick_idx;
                    addr_d          = req_addr[{pick_idx, 6'd0} +: 64];
                    rr_ptr_d        = pick_idx + 2'd1;
                    tx_type_d       = {1'b0, pick_idx} + 3'd1;
                    ack_d[pick_idx] = 1'b1;
                end
            end

            ST_ISSUE: begin
                timer_d = '0;
                state_d = ST_WAIT;
            end

            ST_WAIT: begin
                if (status_match) begin
                    done_d[grant_q] = 1'b1;
                    timer_d         = '0;
                    state_d         = ST_IDLE;
                end else if (timer_q == TIMER_LAST) begin
                    err_d[grant_q] = 1'b1;
                    timer_d        = '0;
                    state_d        = ST_IDLE;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State register. On reset the arbiter returns to IDLE immediately.
    // Any request in flight is dropped, and a status that arrives later
    // lands in IDLE, where it is ignored.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_d;
        end
    end

    // Datapath and registered outputs. Because the reset is asynchronous,
    // every output drops to zero as soon as rst rises, without waiting for
    // a clock edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr_ptr    <= 2'd0;
            grant_q   <= 2'd0;
            addr_q    <= 64'd0;
            timer_q   <= '0;
            tx_type_q <= REQ_NONE;
            req_ack   <= 4'b0000;
            rsp_done  <= 4'b0000;
            rsp_err   <= 4'b0000;
        end else begin
            rr_ptr    <= rr_ptr_d;
            grant_q   <= grant_d;
            addr_q    <= addr_d;
            timer_q   <= timer_d;
            tx_type_q <= tx_type_d;
            req_ack   <= ack_d;
            rsp_done  <= done_d;
            rsp_err   <= err_d;
        end
    end

endmodule

// File: tb/tb_mem_rd_arbiter.sv
// ---------------------------------------------------------------------------
// tb_mem_rd_arbiter
//
// Directed testbench for mem_rd_arbiter, built with TIMEOUT_CYCLES = 8.
// Inputs change on the falling edge. Outputs are sampled 1 time unit after
// the rising edge. Each vector row lists the inputs for one cycle together
// with the outputs expected right after the next rising edge.
// ---------------------------------------------------------------------------
module tb_mem_rd_arbiter;

    localparam int TIMEOUT = 8;

    localparam logic [63:0] A1 = 64'h1000;
    localparam logic [63:0] A2 = 64'h2000;
    localparam logic [63:0] A3 = 64'h3000;
    localparam logic [63:0] A4 = 64'h4000;

    typedef struct {
        logic [3:0]  rv;
        logic [2:0]  st;
        logic [3:0]  ack;
        logic [3:0]  done;
        logic [3:0]  err;
        logic [2:0]  tx_type;
        logic [63:0] tx_addr;
        logic        busy;
        logic [1:0]  grant;
    } vec_t;

    logic         clk;
    logic         rst;
    logic [3:0]   req_valid;
    logic [255:0] req_addr;
    logic [3:0]   req_ack;
    logic [3:0]   rsp_done;
    logic [3:0]   rsp_err;
    logic [66:0]  mem_tx;
    logic [2:0]   mem_rx_status;
    logic         busy;
    logic [1:0]   grant_id;

    int compared;
    int mismatched;

    vec_t vecs[$];

    mem_rd_arbiter #(
        .TIMEOUT_CYCLES(TIMEOUT)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .req_valid     (req_valid),
        .req_addr      (req_addr),
        .req_ack       (req_ack),
        .rsp_done      (rsp_done),
        .rsp_err       (rsp_err),
        .mem_tx        (mem_tx),
        .mem_rx_status (mem_rx_status),
        .busy          (busy),
        .grant_id      (grant_id)
    );

    // 10-unit clock period; the rising edges fall at 5, 15, 25, ...
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Compares one field. Every call counts as one comparison.
    task automatic checkField(input string name, input logic [66:0] act, input logic [66:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Checks all outputs. grant_id is only meaningful while busy, so it is
    // checked only when busy is expected to be high.
    task automatic checkOutput(input string tag, input logic [3:0] e_ack, input logic [3:0] e_done,
                               input logic [3:0] e_err, input logic [2:0] e_type,
                               input logic [63:0] e_addr, input logic e_busy, input logic [1:0] e_grant);
        checkField({tag, ".req_ack"},  67'(req_ack),  67'(e_ack));
        checkField({tag, ".rsp_done"}, 67'(rsp_done), 67'(e_done));
        checkField({tag, ".rsp_err"},  67'(rsp_err),  67'(e_err));
        checkField({tag, ".mem_tx"},   mem_tx,        {e_type, e_addr});
        checkField({tag, ".busy"},     67'(busy),     67'(e_busy));
        if (e_busy) begin
            checkField({tag, ".grant_id"}, 67'(grant_id), 67'(e_grant));
        end
    endtask

    // Drives one cycle of inputs on the falling edge. It then waits until
    // just after the following rising edge, when the outputs are sampled.
    task automatic applyStimulus(input logic [3:0] rv, input logic [2:0] st);
        @(negedge clk);
        req_valid     = rv;
        mem_rx_status = st;
        @(posedge clk);
        #1;
    endtask

    task automatic doReset();
        @(negedge clk);
        rst           = 1'b1;
        req_valid     = 4'b0000;
        mem_rx_status = 3'd0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        #1;
    endtask

    task automatic addVec(input logic [3:0] rv, input logic [2:0] st, input logic [3:0] ack,
                          input logic [3:0] done, input logic [3:0] err, input logic [2:0] tt,
                          input logic [63:0] ta, input logic b, input logic [1:0] g);
        vec_t v;
        v.rv = rv; v.st = st; v.ack = ack; v.done = done; v.err = err;
        v.tx_type = tt; v.tx_addr = ta; v.busy = b; v.grant = g;
        vecs.push_back(v);
    endtask

    initial begin
        logic [1:0]  g;
        logic [63:0] ga;

        compared      = 0;
        mismatched    = 0;
        rst           = 1'b1;
        req_valid     = 4'b0000;
        mem_rx_status = 3'd0;
        req_addr      = {A4, A3, A2, A1};

        // Single INSTR request at 0x1000. The status comes back on the
        // third WAIT cycle, and done follows in the next cycle.
        addVec(4'b0001, 3'd0, 4'b0001, 4'b0000, 4'b0000, 3'd1, A1, 1'b1, 2'd0);
        addVec(4'b0000, 3'd0, 4'b0000, 4'b0000, 4'b0000, 3'd0, A1, 1'b1, 2'd0);
        addVec(4'b0000, 3'd0, 4'b0000, 4'b0000, 4'b0000, 3'd0, A1, 1'b1, 2'd0);
        addVec(4'b0000, 3'd0, 4'b0000, 4'b0000, 4'b0000, 3'd0, A1, 1'b1, 2'd0);
        addVec(4'b0000, 3'd1, 4'b0000, 4'b0001, 4'b0000, 3'd0, A1, 1'b0, 2'd0);
        addVec(4'b0000, 3'd0, 4'b0000, 4'b0000, 4'b0000, 3'd0, A1, 1'b0, 2'd0);
        // RNN_W grant. INSTR_VALID is ignored; RNN_W_VALID completes it.
        addVec(4'b0010, 3'd0, 4'b0010, 4'b0000, 4'b0000, 3'd2, A2, 1'b1, 2'd1);
        addVec(4'b0000, 3'd0, 4'b0000, 4'b0000, 4'b0000, 3'd0, A2, 1'b1, 2'd1);
        addVec(4'b0000, 3'd1, 4'b0000, 4'b0000, 4'b0000, 3'd0, A2, 1'b1, 2'd1);
        addVec(4'b0000, 3'd2, 4'b0000, 4'b0010, 4'b0000, 3'd0, A2, 1'b0, 2'd1);
        // IMAGE grant with no matching status. Err comes on the 8th WAIT
        // cycle, and then the pending INSTR request is served.
        addVec(4'b1000, 3'd0, 4'b1000, 4'b0000, 4'b0000, 3'd4, A4, 1'b1, 2'd3);
        addVec(4'b0001, 3'd0, 4'b0000, 4'b0000, 4'b0000, 3'd0, A4, 1'b1, 2'd3);
        for (int i = 0; i < 7; i++) begin
            addVec(4'b0001, (i == 1) ? 3'd1 : ((i == 3) ? 3'd3 : 3'd0),
                   4'b0000, 4'b0000, 4'b0000, 3'd0, A4, 1'b1, 2'd3);
        end
        addVec(4'b0001, 3'd0, 4'b0000, 4'b0000, 4'b1000, 3'd0, A4, 1'b0, 2'd3);
        addVec(4'b0001, 3'd0, 4'b0001, 4'b0000, 4'b0000, 3'd1, A1, 1'b1, 2'd0);
        addVec(4'b0000, 3'd0, 4'b0000, 4'b0000, 4'b0000, 3'd0, A1, 1'b1, 2'd0);
        // A matching status on the 8th WAIT cycle still counts as done.
        for (int i = 0; i < 7; i++) begin
            addVec(4'b0000, (i == 2) ? 3'd2 : 3'd0,
                   4'b0000, 4'b0000, 4'b0000, 3'd0, A1, 1'b1, 2'd0);
        end
        addVec(4'b0000, 3'd1, 4'b0000, 4'b0001, 4'b0000, 3'd0, A1, 1'b0, 2'd0);
        addVec(4'b0000, 3'd0, 4'b0000, 4'b0000, 4'b0000, 3'd0, A1, 1'b0, 2'd0);

        doReset();
        checkOutput("reset", 4'b0000, 4'b0000, 4'b0000, 3'd0, 64'd0, 1'b0, 2'd0);

        foreach (vecs[i]) begin
            applyStimulus(vecs[i].rv, vecs[i].st);
            checkOutput($sformatf("vec%0d", i), vecs[i].ack, vecs[i].done, vecs[i].err,
                        vecs[i].tx_type, vecs[i].tx_addr, vecs[i].busy, vecs[i].grant);
        end

        // All four requesters are held high, so grants rotate 0,1,2,3,0.
        // Each grant is completed at once, so arbitration runs back to back.
        doReset();
        for (int k = 0; k < 5; k++) begin
            g  = 2'(k % 4);
            ga = 64'h1000 * (64'(g) + 64'd1);
            applyStimulus(4'b1111, 3'd0);
            checkOutput($sformatf("rr%0d.issue", k), 4'b0001 << g, 4'b0000, 4'b0000,
                        3'(g) + 3'd1, ga, 1'b1, g);
            applyStimulus(4'b1111, 3'd0);
            checkOutput($sformatf("rr%0d.wait", k), 4'b0000, 4'b0000, 4'b0000, 3'd0, ga, 1'b1, g);
            applyStimulus(4'b1111, 3'(g) + 3'd1);
            checkOutput($sformatf("rr%0d.done", k), 4'b0000, 4'b0001 << g, 4'b0000, 3'd0, ga, 1'b0, g);
        end

        // Reset is asserted in the middle of WAIT. The outputs must clear at
        // once, and a late IMAGE_VALID must not produce a done.
        doReset();
        applyStimulus(4'b1000, 3'd0);
        checkOutput("rstmid.issue", 4'b1000, 4'b0000, 4'b0000, 3'd4, A4, 1'b1, 2'd3);
        applyStimulus(4'b0000, 3'd0);
        applyStimulus(4'b0000, 3'd0);
        checkOutput("rstmid.wait", 4'b0000, 4'b0000, 4'b0000, 3'd0, A4, 1'b1, 2'd3);
        @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        checkOutput("rstmid.async", 4'b0000, 4'b0000, 4'b0000, 3'd0, 64'd0, 1'b0, 2'd0);
        checkField("rstmid.grant_id", 67'(grant_id), 67'd0);
        @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < 3; k++) begin
            applyStimulus(4'b0000, 3'd4);
            checkOutput($sformatf("rstmid.late%0d", k), 4'b0000, 4'b0000, 4'b0000, 3'd0, 64'd0, 1'b0, 2'd0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
